// File: rtl/display_pkg.sv
// display_pkg: shared widths, digit type, converter states and the double-dabble
// add-3 step for the BCD scan source.
package display_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W = 14;
  localparam int MAX_DISPLAY = 9999;
  typedef logic [DIGIT_W-1:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} conv_state_t;
  function automatic logic [DIGIT_W*NUM_DIGITS-1:0] dabble(input logic [DIGIT_W*NUM_DIGITS-1:0] b);
    logic [DIGIT_W*NUM_DIGITS-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[i*DIGIT_W+:DIGIT_W] = b[i*DIGIT_W+:DIGIT_W] >= 4'd5 ? b[i*DIGIT_W+:DIGIT_W] + 4'd3 : b[i*DIGIT_W+:DIGIT_W];
    return r;
  endfunction
endpackage

// File: rtl/bcd_scan_source_if.sv
// bcd_scan_source_if: load/ready conversion handshake, digit outputs and scan select.
interface bcd_scan_source_if;
  import display_pkg::*;
  logic [BIN_W-1:0] value_in;
  logic load;
  logic ready;
  logic done;
  logic overflow;
  bcd_digit_t digit0, digit1, digit2, digit3;
  logic [1:0] ref_clk;
  modport master (output value_in, load, input ready, done, overflow, digit0, digit1, digit2, digit3, ref_clk);
  modport slave (input value_in, load, output ready, done, overflow, digit0, digit1, digit2, digit3, ref_clk);
endinterface

// File: rtl/refresh_counter.sv
// refresh_counter: free-running prescaler stepping a 2-bit digit-select every REFRESH_DIV clocks.
module refresh_counter #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] ref_clk
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0] pre;
  logic tc;
  always_comb tc = pre == PW'(REFRESH_DIV - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      ref_clk <= '0;
    end else begin
      pre <= tc ? '0 : pre + 1'b1;
      ref_clk <= ref_clk + {1'b0, tc};
    end
  end
endmodule

// File: rtl/bcd_scan_source.sv
// bcd_scan_source: 14-bit binary to 4-digit BCD via iterative double-dabble, plus display scan.
// Define BCD_SATURATE_EN to show 9999 instead of value mod 10000 when the value exceeds 9999.
module bcd_scan_source
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic reset,
  bcd_scan_source_if.slave bus
);
  conv_state_t state, nxt;
  logic [BIN_W-1:0] bin;
  logic [DIGIT_W*NUM_DIGITS-1:0] bcd, adj, res;
  logic [3:0] cnt;
  logic ovf_cap;
  refresh_counter #(.REFRESH_DIV(REFRESH_DIV)) u_refresh (.clk(clk), .reset(reset), .ref_clk(bus.ref_clk));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (bus.load ? CONVERT : IDLE) :
          state == CONVERT ? (cnt == 4'd1 ? UPDATE : CONVERT) : IDLE;
  end
  always_comb begin
    bus.ready = state == IDLE;
    adj = dabble(bcd);
`ifdef BCD_SATURATE_EN
    res = ovf_cap ? 16'h9999 : bcd;
`else
    res = bcd;
`endif
  end
  // Bit 15 of the adjusted accumulator falls off the top, leaving value mod 10000.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_cap <= 1'b0;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
      {bus.digit3, bus.digit2, bus.digit1, bus.digit0} <= '0;
    end else begin
      bus.done <= state == UPDATE;
      if (state == IDLE && bus.load) begin
        bin <= bus.value_in;
        bcd <= '0;
        cnt <= 4'(BIN_W);
        ovf_cap <= bus.value_in > 14'(MAX_DISPLAY);
      end
      if (state == CONVERT) begin
        {bcd, bin} <= {adj[14:0], bin, 1'b0};
        cnt <= cnt - 4'd1;
      end
      if (state == UPDATE) begin
        {bus.digit3, bus.digit2, bus.digit1, bus.digit0} <= res;
        bus.overflow <= ovf_cap;
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_source.sv
// tb_bcd_scan_source: directed vector table plus hand sequences for load-ignore, reset abort and scan.
module tb_bcd_scan_source;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  bcd_scan_source_if bus();
  bcd_scan_source #(.REFRESH_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [13:0] v;
    logic [15:0] d;
    logic o;
  } vec_t;
  vec_t vt[8];
  function automatic logic [15:0] digs();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction
  function automatic logic [15:0] shown(input logic [15:0] d, input logic o);
`ifdef BCD_SATURATE_EN
    return o ? 16'h9999 : d;
`else
    return d;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input logic [13:0] v, input logic [15:0] ed, input logic eo, input int inj, input string nm);
    logic [15:0] prev;
    int dones;
    @(negedge clk);
    bus.load = 1'b1;
    bus.value_in = v;
    @(negedge clk);
    bus.load = 1'b0;
    prev = digs();
    chk({nm, " ready_drop"}, 32'(bus.ready), 32'd0);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk({nm, " hold"}, {15'd0, bus.done, bus.ready, digs()}, {17'd0, prev});
      if (inj != 0 && i == inj) begin
        bus.load = 1'b1;
        bus.value_in = 14'd77;
      end else bus.load = 1'b0;
    end
    @(negedge clk);
    chk({nm, " done"}, {30'd0, bus.done, bus.ready}, 32'd3);
    chk({nm, " digits"}, 32'(digs()), 32'(ed));
    chk({nm, " overflow"}, 32'(bus.overflow), 32'(eo));
    @(negedge clk);
    chk({nm, " done_end"}, 32'(bus.done), 32'd0);
    if (inj != 0) begin
      dones = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      chk({nm, " extra_done"}, 32'(dones), 32'd0);
      chk({nm, " digits_kept"}, 32'(digs()), 32'(ed));
    end
  endtask
  initial begin
    vt[0] = '{14'd0, 16'h0000, 1'b0};
    vt[1] = '{14'd9999, 16'h9999, 1'b0};
    vt[2] = '{14'd12345, 16'h2345, 1'b1};
    vt[3] = '{14'd16383, 16'h6383, 1'b1};
    vt[4] = '{14'd10000, 16'h0000, 1'b1};
    vt[5] = '{14'd1, 16'h0001, 1'b0};
    vt[6] = '{14'd5000, 16'h5000, 1'b0};
    vt[7] = '{14'd8086, 16'h8086, 1'b0};
    reset = 1'b1;
    bus.load = 1'b0;
    bus.value_in = '0;
    #12;
    chk("reset_state", {12'd0, bus.ready, bus.done, bus.overflow, bus.ref_clk, digs()}, {12'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000});
    @(negedge clk);
    reset = 1'b0;
    fork
      for (int k = 1; k <= 24; k++) begin
        @(negedge clk);
        chk("ref_clk", 32'(bus.ref_clk), 32'((k / 4) % 4));
      end
      run(14'd1234, 16'h1234, 1'b0, 0, "v1234");
    join
    for (int i = 0; i < 8; i++) run(vt[i].v, shown(vt[i].d, vt[i].o), vt[i].o, 0, $sformatf("vec%0d", i));
    run(14'd42, 16'h0042, 1'b0, 5, "ignore_load");
    @(negedge clk);
    bus.load = 1'b1;
    bus.value_in = 14'd5678;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_state", {14'd0, bus.ready, bus.done, digs()}, {14'd0, 1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    reset = 1'b0;
    begin
      int dones = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_digits", 32'(digs()), 32'd0);
    end
    run(14'd5678, 16'h5678, 1'b0, 0, "after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
